// File: rtl/sdbp_upload_ctrl.sv
// ============================================================================
// sdbp_upload_ctrl
//
// Purpose:
//   Moves one frame of per-zone gray maxima from the gray FIFO to the LED
//   driver's zone memory. After reset the block first waits out the driver
//   configuration period. It then waits for a trigger, which is either a
//   frame_done pulse or a tick of the free-running period timer. On a trigger
//   it raises the SDBP start flag for FLAG_LEN cycles. It then pops ZONES words
//   from the FIFO and writes them to consecutive zone addresses.
//   A trigger that arrives while an upload is in progress is remembered once.
//   Any further triggers during that upload are dropped.
//
// Compile-time option:
//   SDBP_UPLOAD_TIMEOUT_EN - when defined, TIMEOUT consecutive empty-FIFO
//   cycles in READ abort the transfer and set the sticky err_underrun flag.
//   When undefined, READ waits for data indefinitely and err_underrun is 0.
//
// Ports:
//   clk          in   1  sole clock, rising edge
//   rst          in   1  asynchronous active-high reset
//   frame_done   in   1  single-cycle pulse, a full frame sits in the FIFO
//   fifo_q       in  16  FIFO read data, valid one cycle after fifo_rd_en
//   fifo_empty   in   1  FIFO empty flag
//   fifo_rd_en   out  1  FIFO pop strobe
//   sdbpflag     out  1  SDBP start flag to the LED driver
//   wtaddr       out 10  zone write address
//   wtdina       out 16  zone write data
//   wtvalid      out  1  qualifies wtaddr/wtdina
//   busy         out  1  high while in FLAG or READ
//   err_underrun out  1  sticky transfer-abort flag
// ============================================================================
module sdbp_upload_ctrl #(
    parameter int CFG_WAIT     = 2500,
    parameter int FRAME_PERIOD = 420000,
    parameter int FLAG_LEN     = 29,
    parameter int ZONES        = 360,
    parameter int TIMEOUT      = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_done,
    input  logic [15:0] fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        sdbpflag,
    output logic [9:0]  wtaddr,
    output logic [15:0] wtdina,
    output logic        wtvalid,
    output logic        busy,
    output logic        err_underrun
);

    // Each counter is sized to hold its terminal value without wrapping.
    localparam int CFG_W  = $clog2(CFG_WAIT + 1);
    localparam int PER_W  = $clog2(FRAME_PERIOD + 1);
    localparam int FLAG_W = $clog2(FLAG_LEN + 1);
    localparam int ZONE_W = $clog2(ZONES + 1);

    // Reject parameter sets the address bus or the counters cannot represent.
    if (CFG_WAIT < 1 || FRAME_PERIOD < 2 || FLAG_LEN < 1 ||
        ZONES < 1 || ZONES > 1024 || TIMEOUT < 2) begin : g_bad_params
        $error("sdbp_upload_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        WAIT_CFG = 2'd0,
        IDLE     = 2'd1,
        FLAG     = 2'd2,
        READ     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CFG_W-1:0]    cfg_cnt_q, cfg_cnt_d;
    logic [PER_W-1:0]    timer_q, timer_d;
    logic [FLAG_W-1:0]   flag_cnt_q, flag_cnt_d;
    logic [ZONE_W-1:0]   issued_q, issued_d;
    logic [ZONE_W-1:0]   index_q, index_d;
    logic                pending_q, pending_d;
    logic                pop_q, pop_d;
    logic [9:0]          wtaddr_q, wtaddr_d;
    logic [15:0]         wtdina_q, wtdina_d;

`ifdef SDBP_UPLOAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]     empty_run_q, empty_run_d;
    logic                err_q, err_d;
`endif

    logic in_cfg;
    logic tick;
    logic trigger;
    logic pop;
    logic last_write;

    // The period timer and both trigger sources are held off during
    // configuration. A pop is only issued while data is present and the
    // frame is not yet fully requested. The ZONES-th write ends the transfer.
    always_comb begin
        in_cfg     = (state_q == WAIT_CFG);
        tick       = !in_cfg && (timer_q == PER_W'(FRAME_PERIOD - 1));
        trigger    = !in_cfg && (frame_done || tick);
        pop        = (state_q == READ) && !fifo_empty &&
                     (issued_q < ZONE_W'(ZONES));
        last_write = (state_q == READ) && pop_q &&
                     (index_q == ZONE_W'(ZONES - 1));
    end

    // Next-state and datapath logic.
    // The period timer sits at 0 during configuration. It starts counting
    // on the cycle after configuration ends.
    // issued counts pops and sets the write address.
    // index counts completed writes and decides when the frame is done.
    // They differ because the write lags its pop by one cycle.
    always_comb begin
        state_d    = state_q;
        cfg_cnt_d  = cfg_cnt_q;
        flag_cnt_d = flag_cnt_q;
        issued_d   = issued_q;
        index_d    = index_q;
        pending_d  = pending_q;
        pop_d      = pop;
        wtaddr_d   = wtaddr_q;
        wtdina_d   = wtdina_q;
`ifdef SDBP_UPLOAD_TIMEOUT_EN
        empty_run_d = '0;
        err_d       = err_q;
`endif

        if (in_cfg || tick) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + PER_W'(1);
        end

        if (pop) begin
            wtaddr_d = 10'(issued_q);
        end
        if (pop_q) begin
            wtdina_d = fifo_q;
        end

        unique case (state_q)
            WAIT_CFG: begin
                if (cfg_cnt_q == CFG_W'(CFG_WAIT - 1)) begin
                    state_d   = IDLE;
                    cfg_cnt_d = '0;
                end else begin
                    cfg_cnt_d = cfg_cnt_q + CFG_W'(1);
                end
            end

            IDLE: begin
                flag_cnt_d = '0;
                if (pending_q) begin
                    state_d   = FLAG;
                    pending_d = 1'b0;
                end else if (trigger) begin
                    state_d = FLAG;
                end
            end

            FLAG: begin
                if (trigger) begin
                    pending_d = 1'b1;
                end
                if (flag_cnt_q == FLAG_W'(FLAG_LEN - 1)) begin
                    state_d    = READ;
                    flag_cnt_d = '0;
                end else begin
                    flag_cnt_d = flag_cnt_q + FLAG_W'(1);
                end
            end

            READ: begin
                if (trigger) begin
                    pending_d = 1'b1;
                end
                if (pop) begin
                    issued_d = issued_q + ZONE_W'(1);
                end
                if (pop_q) begin
                    index_d = index_q + ZONE_W'(1);
                end
                if (last_write) begin
                    state_d  = IDLE;
                    issued_d = '0;
                    index_d  = '0;
                end
`ifdef SDBP_UPLOAD_TIMEOUT_EN
                // A non-empty cycle restarts the run.
                // An abort keeps pending, so a trigger queued during
                // the failed transfer still starts a new one.
                else if (fifo_empty) begin
                    if (empty_run_q == TO_W'(TIMEOUT - 1)) begin
                        state_d  = IDLE;
                        issued_d = '0;
                        index_d  = '0;
                        err_d    = 1'b1;
                    end else begin
                        empty_run_d = empty_run_q + TO_W'(1);
                    end
                end
`endif
            end

            default: begin
                state_d = WAIT_CFG;
            end
        endcase
    end

    // State and datapath registers.
    // rst clears every register at once. An upload in progress stops
    // immediately, and the sequence restarts from configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_CFG;
            cfg_cnt_q  <= '0;
            timer_q    <= '0;
            flag_cnt_q <= '0;
            issued_q   <= '0;
            index_q    <= '0;
            pending_q  <= 1'b0;
            pop_q      <= 1'b0;
            wtaddr_q   <= '0;
            wtdina_q   <= '0;
        end else begin
            state_q    <= state_d;
            cfg_cnt_q  <= cfg_cnt_d;
            timer_q    <= timer_d;
            flag_cnt_q <= flag_cnt_d;
            issued_q   <= issued_d;
            index_q    <= index_d;
            pending_q  <= pending_d;
            pop_q      <= pop_d;
            wtaddr_q   <= wtaddr_d;
            wtdina_q   <= wtdina_d;
        end
    end

`ifdef SDBP_UPLOAD_TIMEOUT_EN
    // Empty-run counter and sticky abort flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            empty_run_q <= '0;
            err_q       <= 1'b0;
        end else begin
            empty_run_q <= empty_run_d;
            err_q       <= err_d;
        end
    end

    assign err_underrun = err_q;
`else
    assign err_underrun = 1'b0;
`endif

    // FIFO data arrives in the cycle after its pop. wtdina therefore passes
    // fifo_q straight through on that cycle. On other cycles it shows the
    // last word written, so the write bus holds steady between writes.
    assign fifo_rd_en = pop;
    assign sdbpflag   = (state_q == FLAG);
    assign busy       = (state_q == FLAG) || (state_q == READ);
    assign wtvalid    = pop_q;
    assign wtaddr     = wtaddr_q;
    assign wtdina     = pop_q ? fifo_q : wtdina_q;

endmodule

// File: tb/tb_sdbp_upload_ctrl.sv
// ============================================================================
// tb_sdbp_upload_ctrl
//
// Directed testbench for sdbp_upload_ctrl. The DUT uses the default
// configuration wait, flag length and zone count, with a short frame period
// so the timer tick can be reached. A small behavioural FIFO feeds the DUT.
// Word k of every frame holds the value k, so wtdina must equal wtaddr.
// ============================================================================
module tb_sdbp_upload_ctrl;

    localparam int CFG_WAIT     = 2500;
    localparam int FRAME_PERIOD = 8000;
    localparam int FLAG_LEN     = 29;
    localparam int ZONES        = 360;
    localparam int TIMEOUT      = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_done = 1'b0;
    logic [15:0] fifo_q = '0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        sdbpflag;
    logic [9:0]  wtaddr;
    logic [15:0] wtdina;
    logic        wtvalid;
    logic        busy;
    logic        err_underrun;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc;

    logic [15:0] fifo_mem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        force_empty = 1'b0;

    typedef struct {
        int writes;
        int addr_err;
        int data_err;
        int empty_pops;
        int flag_cycles;
        int first_flag_cyc;
        int last_pop_i;
        int fall_i;
        bit done;
    } obs_t;

    sdbp_upload_ctrl #(
        .CFG_WAIT     (CFG_WAIT),
        .FRAME_PERIOD (FRAME_PERIOD),
        .FLAG_LEN     (FLAG_LEN),
        .ZONES        (ZONES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_done   (frame_done),
        .fifo_q       (fifo_q),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .sdbpflag     (sdbpflag),
        .wtaddr       (wtaddr),
        .wtdina       (wtdina),
        .wtvalid      (wtvalid),
        .busy         (busy),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Behavioural gray FIFO with data one cycle after the pop.
    assign fifo_empty = (wr_ptr == rd_ptr) || force_empty;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_q <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr] = 16'(i);
            wr_ptr++;
        end
    endtask

    // Drives frame_done pulses at the given cycle offsets and records what
    // the DUT emits. The loop stops once busy has risen and then fallen.
    task automatic observe(input int max_cycles, input int pa, input int pb,
                           input int pc, input bit toggle, output obs_t r);
        bit seen_busy = 1'b0;
        r.writes = 0; r.addr_err = 0; r.data_err = 0; r.empty_pops = 0;
        r.flag_cycles = 0; r.first_flag_cyc = -1; r.last_pop_i = -1;
        r.fall_i = -1; r.done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            frame_done = (i == pa) || (i == pb) || (i == pc);
            if (toggle && busy) force_empty = ~force_empty;
            #1;
            if (sdbpflag) begin
                r.flag_cycles++;
                if (r.first_flag_cyc < 0) r.first_flag_cyc = cyc;
            end
            if (fifo_rd_en) begin
                r.last_pop_i = i;
                if (fifo_empty) r.empty_pops++;
            end
            if (wtvalid) begin
                if (wtaddr !== 10'(r.writes)) r.addr_err++;
                if (wtdina !== 16'(r.writes)) r.data_err++;
                r.writes++;
            end
            if (busy) seen_busy = 1'b1;
            else if (seen_busy) begin
                r.done = 1'b1;
                r.fall_i = i;
                break;
            end
        end
        frame_done  = 1'b0;
        force_empty = 1'b0;
    endtask

    // Checks the reset state. Then releases reset and checks that frame_done
    // is ignored at cycle 100 and at the last configuration cycle.
    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        frame_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({sdbpflag, fifo_rd_en, wtvalid, busy, err_underrun, wtaddr, wtdina} !== 31'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %b, expected all zero",
                     {sdbpflag, fifo_rd_en, wtvalid, busy, err_underrun, wtaddr, wtdina});
        end
        push_words(ZONES);
        @(negedge clk);
        rst = 1'b0;
        while (cyc < CFG_WAIT - 1) begin
            @(negedge clk);
            frame_done = (cyc == 100) || (cyc == CFG_WAIT - 1);
            #1;
            if (busy || sdbpflag || fifo_rd_en) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("[TB] FAIL cfg_ignores_trigger: got %0d active cycles, expected 0", bad);
        end
    endtask

    // First frame_done after configuration uploads a full frame.
    task automatic test_upload();
        obs_t r;
        observe(600, 0, -1, -1, 1'b0, r);
        tests_run++;
        if (r.done !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL upload_done: got %0d, expected 1", r.done);
        end
        tests_run++;
        if (r.first_flag_cyc !== CFG_WAIT + 1) begin
            tests_failed++; $display("[TB] FAIL upload_flag_start: got %0d, expected %0d", r.first_flag_cyc, CFG_WAIT + 1);
        end
        tests_run++;
        if (r.flag_cycles !== FLAG_LEN) begin
            tests_failed++; $display("[TB] FAIL upload_flag_len: got %0d, expected %0d", r.flag_cycles, FLAG_LEN);
        end
        tests_run++;
        if (r.writes !== ZONES) begin
            tests_failed++; $display("[TB] FAIL upload_writes: got %0d, expected %0d", r.writes, ZONES);
        end
        tests_run++;
        if (r.addr_err !== 0 || r.data_err !== 0) begin
            tests_failed++; $display("[TB] FAIL upload_addr_data: got %0d/%0d errors, expected 0/0", r.addr_err, r.data_err);
        end
        tests_run++;
        if (wtaddr !== 10'd359 || wtvalid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL upload_addr_hold: got addr %0d valid %0d, expected 359 0", wtaddr, wtvalid);
        end
    endtask

    // FIFO empty every other cycle: no pop while empty, contiguous writes.
    task automatic test_empty_toggle();
        obs_t r;
        push_words(ZONES);
        observe(2000, 0, -1, -1, 1'b1, r);
        tests_run++;
        if (r.done !== 1'b1 || r.writes !== ZONES) begin
            tests_failed++; $display("[TB] FAIL toggle_writes: got done %0d writes %0d, expected 1 %0d", r.done, r.writes, ZONES);
        end
        tests_run++;
        if (r.empty_pops !== 0) begin
            tests_failed++; $display("[TB] FAIL toggle_pop_when_empty: got %0d, expected 0", r.empty_pops);
        end
        tests_run++;
        if (r.addr_err !== 0 || r.data_err !== 0) begin
            tests_failed++; $display("[TB] FAIL toggle_addr_data: got %0d/%0d errors, expected 0/0", r.addr_err, r.data_err);
        end
    endtask

    // Two frame_done pulses during READ yield exactly one follow-on upload.
    task automatic test_back_to_back();
        obs_t r1, r2, r3;
        int end_cyc;
        push_words(ZONES);
        push_words(ZONES);
        observe(800, 0, 100, 150, 1'b0, r1);
        end_cyc = cyc;
        tests_run++;
        if (r1.done !== 1'b1 || r1.writes !== ZONES) begin
            tests_failed++; $display("[TB] FAIL b2b_first: got done %0d writes %0d, expected 1 %0d", r1.done, r1.writes, ZONES);
        end
        observe(800, -1, -1, -1, 1'b0, r2);
        tests_run++;
        if (r2.first_flag_cyc !== end_cyc + 1) begin
            tests_failed++; $display("[TB] FAIL b2b_pending_start: got %0d, expected %0d", r2.first_flag_cyc, end_cyc + 1);
        end
        tests_run++;
        if (r2.done !== 1'b1 || r2.writes !== ZONES || r2.addr_err !== 0 || r2.data_err !== 0) begin
            tests_failed++; $display("[TB] FAIL b2b_second: got done %0d writes %0d errs %0d/%0d, expected 1 %0d 0/0",
                                     r2.done, r2.writes, r2.addr_err, r2.data_err, ZONES);
        end
        observe(200, -1, -1, -1, 1'b0, r3);
        tests_run++;
        if (r3.flag_cycles !== 0) begin
            tests_failed++; $display("[TB] FAIL b2b_no_third: got %0d flag cycles, expected 0", r3.flag_cycles);
        end
    endtask

    // FIFO holds only 100 words.
    task automatic test_timeout();
        obs_t r;
        push_words(100);
        observe(1300, 0, -1, -1, 1'b0, r);
        tests_run++;
        if (r.writes !== 100) begin
            tests_failed++; $display("[TB] FAIL timeout_writes: got %0d, expected 100", r.writes);
        end
`ifdef SDBP_UPLOAD_TIMEOUT_EN
        tests_run++;
        if (r.done !== 1'b1 || r.fall_i - r.last_pop_i !== TIMEOUT + 1) begin
            tests_failed++; $display("[TB] FAIL timeout_abort: got done %0d delay %0d, expected 1 %0d",
                                     r.done, r.fall_i - r.last_pop_i, TIMEOUT + 1);
        end
        tests_run++;
        if (err_underrun !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL timeout_err: got %0d, expected 1", err_underrun);
        end
`else
        tests_run++;
        if (r.done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL timeout_wait_read: got done %0d busy %0d, expected 0 1", r.done, busy);
        end
        tests_run++;
        if (err_underrun !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL timeout_err: got %0d, expected 0", err_underrun);
        end
`endif
    endtask

    // Reset at wtaddr 200 aborts at once. Then the full configuration and a
    // full upload follow.
    task automatic test_reset_mid();
        obs_t r;
        int   bad = 0;
        int   snap;
        bit   found = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wr_ptr = rd_ptr;
        push_words(ZONES);
        @(negedge clk);
        rst = 1'b0;
        while (cyc < CFG_WAIT) @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            #1;
            if (wtvalid && wtaddr == 10'd200) found = 1'b1;
        end
        tests_run++;
        if (found !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL mid_reach_200: got %0d, expected 1", found);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({sdbpflag, fifo_rd_en, wtvalid, busy, err_underrun, wtaddr, wtdina} !== 31'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_outputs: got %b, expected all zero",
                     {sdbpflag, fifo_rd_en, wtvalid, busy, err_underrun, wtaddr, wtdina});
        end
        snap = rd_ptr;
        repeat (4) @(negedge clk);
        tests_run++;
        if (rd_ptr !== snap) begin
            tests_failed++; $display("[TB] FAIL mid_reset_no_pop: got %0d pops, expected 0", rd_ptr - snap);
        end
        wr_ptr = rd_ptr;
        push_words(ZONES);
        rst = 1'b0;
        while (cyc < CFG_WAIT - 1) begin
            @(negedge clk);
            frame_done = (cyc == 50) || (cyc == CFG_WAIT - 1);
            #1;
            if (busy || sdbpflag || fifo_rd_en) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++; $display("[TB] FAIL mid_cfg_ignores_trigger: got %0d active cycles, expected 0", bad);
        end
        observe(600, 0, -1, -1, 1'b0, r);
        tests_run++;
        if (r.first_flag_cyc !== CFG_WAIT + 1 || r.done !== 1'b1 || r.writes !== ZONES || r.addr_err !== 0) begin
            tests_failed++; $display("[TB] FAIL mid_restart_upload: got flag %0d done %0d writes %0d aerr %0d, expected %0d 1 %0d 0",
                                     r.first_flag_cyc, r.done, r.writes, r.addr_err, CFG_WAIT + 1, ZONES);
        end
    endtask

    // With no frame_done, the period timer alone must raise the flag.
    // The flag should first appear FRAME_PERIOD cycles after configuration ends.
    task automatic test_tick();
        while (!sdbpflag && cyc < CFG_WAIT + FRAME_PERIOD + 200) begin
            @(negedge clk);
            #1;
        end
        tests_run++;
        if (sdbpflag !== 1'b1 || cyc !== CFG_WAIT + FRAME_PERIOD) begin
            tests_failed++; $display("[TB] FAIL tick_flag: got flag %0d at cycle %0d, expected 1 at %0d",
                                     sdbpflag, cyc, CFG_WAIT + FRAME_PERIOD);
        end
    endtask

    initial begin
        test_reset();
        test_upload();
        test_empty_toggle();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
